// File: rtl/fpu_float_to_int_seq.sv
// IEEE-754 single-precision to signed 32-bit integer converter (round-to-nearest-even).
// Normal operands are aligned one bit per cycle; specials resolve in a single cycle.
module fpu_float_to_int_seq #(
  parameter int unsigned MAX_RSHIFT = 25
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_a,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_int,
  output logic        o_invalid,
  output logic        o_inexact
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned CNT_W  = 5;

  // Exponent field where the integer LSB sits at the significand LSB (127 + 23).
  localparam logic [EXP_W-1:0]  EXP_ALIGN = EXP_W'(150);
  // Exponent field at which |value| >= 2^31 (127 + 31).
  localparam logic [EXP_W-1:0]  EXP_SAT   = EXP_W'(158);
  localparam logic [EXP_W-1:0]  EXP_MAX   = '1;
  localparam logic [WORD_W-1:0] INT_MAX   = 32'h7FFF_FFFF;
  localparam logic [WORD_W-1:0] INT_MIN   = 32'h8000_0000;
  localparam logic [WORD_W-1:0] FLT_MIN31 = 32'hCF00_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q,   state_d;
  logic                sign_q,    sign_d;
  logic                left_q,    left_d;
  logic [WORD_W-1:0]   mag_q,     mag_d;
  logic                guard_q,   guard_d;
  logic                sticky_q,  sticky_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                valid_q,   valid_d;
  logic [WORD_W-1:0]   int_q,     int_d;
  logic                invalid_q, invalid_d;
  logic                inexact_q, inexact_d;

  logic [EXP_W-1:0]    exp_w;
  logic [FRAC_W-1:0]   frac_w;
  logic [EXP_W-1:0]    rsh_w;
  logic                is_nan_w;
  logic                is_zero_w;
  logic                is_sub_w;
  logic                is_min_w;
  logic                is_big_w;
  logic                round_up_w;
  logic [WORD_W-1:0]   mag_rnd_w;

  // Operand field decode, only meaningful in IDLE.
  always_comb begin
    exp_w     = i_a[30:23];
    frac_w    = i_a[22:0];
    rsh_w     = EXP_ALIGN - exp_w;
    is_nan_w  = (exp_w == EXP_MAX) && (frac_w != '0);
    is_zero_w = (exp_w == '0) && (frac_w == '0);
    is_sub_w  = (exp_w == '0) && (frac_w != '0);
    is_min_w  = (i_a == FLT_MIN31);
    is_big_w  = (exp_w >= EXP_SAT);
  end

  // Round-to-nearest-even on the aligned magnitude.
  always_comb begin
    round_up_w = guard_q & (sticky_q | mag_q[0]);
    mag_rnd_w  = mag_q + WORD_W'(round_up_w);
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    left_d    = left_q;
    mag_d     = mag_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    int_d     = int_q;
    invalid_d = invalid_q;
    inexact_d = inexact_q;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (is_nan_w) begin
            int_d     = INT_MAX;
            invalid_d = 1'b1;
            inexact_d = 1'b0;
            valid_d   = 1'b1;
            state_d   = S_DONE;
          end else if (is_min_w) begin
            int_d     = INT_MIN;
            invalid_d = 1'b0;
            inexact_d = 1'b0;
            valid_d   = 1'b1;
            state_d   = S_DONE;
          end else if (is_big_w) begin
            int_d     = i_a[31] ? INT_MIN : INT_MAX;
            invalid_d = 1'b1;
            inexact_d = 1'b0;
            valid_d   = 1'b1;
            state_d   = S_DONE;
          end else if (is_zero_w || is_sub_w) begin
            int_d     = '0;
            invalid_d = 1'b0;
            inexact_d = is_sub_w;
            valid_d   = 1'b1;
            state_d   = S_DONE;
          end else begin
            sign_d    = i_a[31];
            mag_d     = {{(WORD_W-FRAC_W-1){1'b0}}, 1'b1, frac_w};
            guard_d   = 1'b0;
            sticky_d  = 1'b0;
            invalid_d = 1'b0;
            inexact_d = 1'b0;
            if (exp_w >= EXP_ALIGN) begin
              left_d = 1'b1;
              cnt_d  = CNT_W'(exp_w - EXP_ALIGN);
            end else begin
              left_d = 1'b0;
              cnt_d  = (rsh_w > EXP_W'(MAX_RSHIFT)) ? CNT_W'(MAX_RSHIFT) : CNT_W'(rsh_w);
            end
            state_d = (cnt_d == '0) ? S_ROUND : S_SHIFT;
          end
        end
      end

      // One alignment step per cycle; bits leaving the LSB feed guard, then sticky.
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_ROUND;
        end else begin
          if (left_q) begin
            mag_d = {mag_q[WORD_W-2:0], 1'b0};
          end else begin
            mag_d    = {1'b0, mag_q[WORD_W-1:1]};
            guard_d  = mag_q[0];
            sticky_d = sticky_q | guard_q;
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_ROUND;
          end
        end
      end

      S_ROUND: begin
        int_d     = sign_q ? (~mag_rnd_w + WORD_W'(1)) : mag_rnd_w;
        inexact_d = guard_q | sticky_q;
        invalid_d = 1'b0;
        valid_d   = 1'b1;
        state_d   = S_DONE;
      end

      S_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      left_q    <= 1'b0;
      mag_q     <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      int_q     <= '0;
      invalid_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      left_q    <= left_d;
      mag_q     <= mag_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      int_q     <= int_d;
      invalid_q <= invalid_d;
      inexact_q <= inexact_d;
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_valid   = valid_q;
  assign o_int     = int_q;
  assign o_invalid = invalid_q;
  assign o_inexact = inexact_q;

endmodule
